// File: rtl/kbd_pkg.sv
// kbd_pkg -- shared constants for the keyboard event encoder.
//
// Holds the event codes placed in keyboard_input[6:5], the one-hot key codes
// placed in keyboard_input[4:0], the PS/2 prefix bytes, the scan codes of both
// player key maps, the event FSM state type and the scan-code to key mapping.
package kbd_pkg;

    // Event field codes; 2'b00 means "key held, no event this cycle".
    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_HOLD    = 2'b11;
    localparam logic [1:0] EVT_RELEASE = 2'b10;

    // One-hot key codes as consumed by the player block.
    localparam logic [4:0] KEY_NONE        = 5'b00000;
    localparam logic [4:0] KEY_HOLD_CANNON = 5'b00001;
    localparam logic [4:0] KEY_ANGLE_DOWN  = 5'b00010;
    localparam logic [4:0] KEY_ANGLE_UP    = 5'b00100;
    localparam logic [4:0] KEY_BACKWARD    = 5'b01000;
    localparam logic [4:0] KEY_FORWARD     = 5'b10000;

    // PS/2 set-2 prefix bytes.
    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BREAK = 8'hF0;

    // Player 1: plain (non-extended) codes.
    localparam logic [7:0] SC1_ANGLE_UP    = 8'h1D;
    localparam logic [7:0] SC1_ANGLE_DOWN  = 8'h1B;
    localparam logic [7:0] SC1_BACKWARD    = 8'h1C;
    localparam logic [7:0] SC1_FORWARD     = 8'h23;
    localparam logic [7:0] SC1_HOLD_CANNON = 8'h29;

    // Player 2: arrow keys are extended codes, cannon key is plain.
    localparam logic [7:0] SC2_ANGLE_UP    = 8'h75;
    localparam logic [7:0] SC2_ANGLE_DOWN  = 8'h72;
    localparam logic [7:0] SC2_BACKWARD    = 8'h6B;
    localparam logic [7:0] SC2_FORWARD     = 8'h74;
    localparam logic [7:0] SC2_HOLD_CANNON = 8'h5A;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HOLD,
        RELEASE
    } state_t;

    // Returns the one-hot key for a scan code, or KEY_NONE when unmapped.
    function automatic logic [4:0] map_key(input logic pos, input logic ext,
                                           input logic [7:0] code);
        logic [4:0] k;
        k = KEY_NONE;
        if (!pos) begin
            if (!ext) begin
                case (code)
                    SC1_ANGLE_UP:    k = KEY_ANGLE_UP;
                    SC1_ANGLE_DOWN:  k = KEY_ANGLE_DOWN;
                    SC1_BACKWARD:    k = KEY_BACKWARD;
                    SC1_FORWARD:     k = KEY_FORWARD;
                    SC1_HOLD_CANNON: k = KEY_HOLD_CANNON;
                    default:         k = KEY_NONE;
                endcase
            end
        end else begin
            if (ext) begin
                case (code)
                    SC2_ANGLE_UP:   k = KEY_ANGLE_UP;
                    SC2_ANGLE_DOWN: k = KEY_ANGLE_DOWN;
                    SC2_BACKWARD:   k = KEY_BACKWARD;
                    SC2_FORWARD:    k = KEY_FORWARD;
                    default:        k = KEY_NONE;
                endcase
            end else if (code == SC2_HOLD_CANNON) begin
                k = KEY_HOLD_CANNON;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/kbd_event_encoder_ps2_rx.sv
// ps2_rx -- PS/2 device-to-host frame receiver.
//
// Synchronizes the raw PS/2 lines, samples data on each falling edge of the
// synchronized PS/2 clock and assembles 11-bit frames (start, 8 data LSB
// first, odd parity, stop). A good frame gives a one-cycle byte_valid with the
// byte on rx_byte; a bad frame or a mid-frame idle timeout gives a one-cycle err.
//
// Build option: KBD_PARITY_CHECK_EN -- when defined, frames failing odd parity
// are dropped with err; otherwise the parity bit is sampled and ignored.
//
// Ports:
//   clock      system clock
//   rst        synchronous active-high reset
//   ps2_clk    raw asynchronous PS/2 clock
//   ps2_data   raw asynchronous PS/2 data
//   rx_byte    last received data byte (valid with byte_valid)
//   byte_valid one-cycle pulse per accepted frame
//   err        one-cycle pulse per dropped frame
module ps2_rx #(
    parameter logic [13:0] TIMEOUT_CYCLES = 14'd10_000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    // Bit 0 = PS/2 clock, bit 1 = PS/2 data.
    logic [1:0] raw_bits;
    logic [1:0] sync_bits;
    assign raw_bits = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Idle level of both PS/2 lines is high.
            always_ff @(posedge clock) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw_bits[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic        clk_prev_reg;
    logic [3:0]  bit_cnt_reg;
    logic [9:0]  shift_reg;
    logic [13:0] idle_cnt_reg;
    logic [7:0]  rx_byte_reg;
    logic        byte_valid_reg;
    logic        err_reg;

    logic        ps2_fall;
    logic [10:0] full_frame;
    logic        parity_ok;
    logic        frame_ok;

    assign ps2_fall = clk_prev_reg & ~sync_bits[0];

    // New bits enter at the top, so once the stop bit arrives the frame reads
    // [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign full_frame = {sync_bits[1], shift_reg};

`ifdef KBD_PARITY_CHECK_EN
    assign parity_ok = ^full_frame[9:1];
`else
    // Parity is still shifted in with the frame but never vetoes it.
    assign parity_ok = (^full_frame[9:1]) | 1'b1;
`endif

    assign frame_ok = ~full_frame[0] & full_frame[10] & parity_ok;

    always_ff @(posedge clock) begin
        if (rst) begin
            clk_prev_reg   <= 1'b1;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 10'd0;
            idle_cnt_reg   <= 14'd0;
            rx_byte_reg    <= 8'd0;
            byte_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            clk_prev_reg   <= sync_bits[0];
            byte_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            if (ps2_fall) begin
                idle_cnt_reg <= 14'd0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= 4'd0;
                    if (frame_ok) begin
                        rx_byte_reg    <= full_frame[8:1];
                        byte_valid_reg <= 1'b1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end else begin
                    shift_reg   <= {sync_bits[1], shift_reg[9:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else if (bit_cnt_reg != 4'd0) begin
                // Mid-frame: abort if the keyboard stalls too long.
                if (idle_cnt_reg == TIMEOUT_CYCLES - 14'd1) begin
                    bit_cnt_reg  <= 4'd0;
                    idle_cnt_reg <= 14'd0;
                    err_reg      <= 1'b1;
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + 14'd1;
                end
            end else begin
                idle_cnt_reg <= 14'd0;
            end
        end
    end

    assign rx_byte    = rx_byte_reg;
    assign byte_valid = byte_valid_reg;
    assign err        = err_reg;

endmodule

// File: rtl/kbd_event_encoder.sv
// kbd_event_encoder -- PS/2 keyboard to player key-event encoder.
//
// Receives PS/2 scan codes, tracks the E0/F0 prefixes, maps codes of one
// player's key set and runs a single-key IDLE/PRESS/HOLD/RELEASE FSM that
// emits press, periodic hold and release events.
//
// Build option: KBD_PARITY_CHECK_EN (see ps2_rx) enables parity checking.
//
// Ports:
//   clock          system clock
//   rst            synchronous active-high reset
//   ps2_clk        raw asynchronous PS/2 clock
//   ps2_data       raw asynchronous PS/2 data
//   keyboard_input {event[1:0], key[4:0]} for the player block
//   frame_err      one-cycle pulse when a PS/2 frame is dropped
module kbd_event_encoder
    import kbd_pkg::*;
#(
    parameter logic        Position       = 1'b0,
    parameter logic [22:0] HOLD_PERIOD    = 23'd5_000_000,
    parameter logic [13:0] TIMEOUT_CYCLES = 14'd10_000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] keyboard_input,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_err;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock     (clock),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .err       (rx_err)
    );

    logic ext_reg;
    logic brk_reg;
    logic is_prefix;
    logic [4:0] key_code;
    logic key_evt;

    assign is_prefix = (rx_byte == PREFIX_EXT) || (rx_byte == PREFIX_BREAK);
    assign key_code  = map_key(Position, ext_reg, rx_byte);
    assign key_evt   = byte_valid && !is_prefix && (key_code != KEY_NONE);

    // Prefix flags apply to the next non-prefix byte only.
    always_ff @(posedge clock) begin
        if (rst) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == PREFIX_EXT) begin
                ext_reg <= 1'b1;
            end else if (rx_byte == PREFIX_BREAK) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    state_t      state_reg;
    logic [4:0]  key_reg;
    logic [22:0] hold_cnt_reg;
    logic [6:0]  out_reg;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg    <= IDLE;
            key_reg      <= KEY_NONE;
            hold_cnt_reg <= 23'd0;
            out_reg      <= 7'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_evt && !brk_reg) begin
                        state_reg <= PRESS;
                        key_reg   <= key_code;
                        out_reg   <= {EVT_PRESS, key_code};
                    end else begin
                        out_reg <= 7'd0;
                    end
                end
                PRESS: begin
                    state_reg    <= HOLD;
                    hold_cnt_reg <= 23'd0;
                    out_reg      <= {EVT_NONE, key_reg};
                end
                HOLD: begin
                    // A matching break wins over a hold pulse due this cycle.
                    if (key_evt && brk_reg && (key_code == key_reg)) begin
                        state_reg <= RELEASE;
                        out_reg   <= {EVT_RELEASE, key_reg};
                    end else if (hold_cnt_reg == HOLD_PERIOD - 23'd1) begin
                        hold_cnt_reg <= 23'd0;
                        out_reg      <= {EVT_HOLD, key_reg};
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 23'd1;
                        out_reg      <= {EVT_NONE, key_reg};
                    end
                end
                RELEASE: begin
                    state_reg <= IDLE;
                    key_reg   <= KEY_NONE;
                    out_reg   <= 7'd0;
                end
                default: begin
                    state_reg <= IDLE;
                    key_reg   <= KEY_NONE;
                    out_reg   <= 7'd0;
                end
            endcase
        end
    end

    assign keyboard_input = out_reg;
    assign frame_err      = rx_err;

endmodule

// File: tb/tb_kbd_event_encoder.sv
// Testbench for kbd_event_encoder: one player-1 and one player-2 instance share
// the PS/2 lines; a per-cycle monitor checks each output against queued
// expected events, bench-held expected keys and the hold pulse spacing.
module tb_kbd_event_encoder;

    localparam logic [22:0] HP   = 23'd50;
    localparam logic [13:0] TO   = 14'd100;
    localparam int          HALF = 10;
    localparam int          GAP  = 40;

    logic       clock;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [6:0] ki0;
    logic [6:0] ki1;
    logic       ferr0;
    logic       ferr1;

    kbd_event_encoder #(
        .Position(1'b0), .HOLD_PERIOD(HP), .TIMEOUT_CYCLES(TO)
    ) dut0 (
        .clock(clock), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_input(ki0), .frame_err(ferr0)
    );

    kbd_event_encoder #(
        .Position(1'b1), .HOLD_PERIOD(HP), .TIMEOUT_CYCLES(TO)
    ) dut1 (
        .clock(clock), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_input(ki1), .frame_err(ferr1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard state, one slot per instance.
    logic [6:0] exp_q0[$];
    logic [6:0] exp_q1[$];
    logic [4:0] exp_key[2];
    int         exp_err[2];
    bit         held[2];
    int         mark[2];
    bit         mark_press[2];
    int         holds[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // 7'h7F is never a press/release code, so an empty queue always mismatches.
    function automatic logic [6:0] pop_exp(input int d);
        logic [6:0] v;
        v = 7'h7F;
        if (d == 0) begin
            if (exp_q0.size() > 0) v = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() > 0) v = exp_q1.pop_front();
        end
        return v;
    endfunction

    task automatic mon(input int d, input logic [6:0] ki, input logic ferr);
        case (ki[6:5])
            2'b01, 2'b10: begin
                chk($sformatf("evt%0d", d), {25'd0, ki}, {25'd0, pop_exp(d)});
                held[d]       = (ki[6:5] == 2'b01);
                mark[d]       = cyc;
                mark_press[d] = 1'b1;
            end
            2'b11: begin
                chk($sformatf("hold_state%0d", d), {31'd0, held[d]}, 32'd1);
                chk($sformatf("hold_key%0d", d), {25'd0, ki}, {25'd0, 2'b11, exp_key[d]});
                chk($sformatf("hold_gap%0d", d), cyc - mark[d],
                    mark_press[d] ? int'(HP) + 1 : int'(HP));
                mark[d]       = cyc;
                mark_press[d] = 1'b0;
                holds[d]++;
            end
            default: begin
                chk($sformatf("steady%0d", d), {25'd0, ki},
                    held[d] ? {25'd0, 2'b00, exp_key[d]} : 32'd0);
            end
        endcase
        if (ferr) begin
            chk($sformatf("err_expected%0d", d), {31'd0, exp_err[d] > 0}, 32'd1);
            if (exp_err[d] > 0) exp_err[d]--;
        end
    endtask

    always @(negedge clock) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                held[d]       = 1'b0;
                mark[d]       = cyc;
                mark_press[d] = 1'b1;
            end
        end else begin
            mon(0, ki0, ferr0);
            mon(1, ki1, ferr1);
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip = 1'b0,
                              input logic start_v = 1'b0, input logic stop_v = 1'b1);
        logic p;
        p = ~(^b) ^ par_flip;
        $display("[TB] frame %02h par_flip=%0d start=%0d stop=%0d", b, par_flip, start_v, stop_v);
        ps2_bit(start_v);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(stop_v);
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clock);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        for (int d = 0; d < 2; d++) begin
            exp_key[d] = 5'd0;
            exp_err[d] = 0;
            holds[d]   = 0;
        end
        repeat (4) @(posedge clock);
        #1;
        chk("rst_ki0", {25'd0, ki0}, 32'd0);
        chk("rst_ki1", {25'd0, ki1}, 32'd0);
        chk("rst_ferr0", {31'd0, ferr0}, 32'd0);
        chk("rst_ferr1", {31'd0, ferr1}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clock);

        // Player 1 forward: press, hold pulses, release.
        exp_key[0] = 5'b10000;
        exp_q0.push_back(7'b01_10000);
        send_frame(8'h23);
        repeat (200) @(posedge clock);
        chk("hold_seen0", {31'd0, holds[0] != 0}, 32'd1);
        exp_q0.push_back(7'b10_10000);
        send_frame(8'hF0);
        send_frame(8'h23);
        repeat (20) @(posedge clock);

        // Player 2 extended angle_up; same codes are unmapped for player 1.
        exp_key[1] = 5'b00100;
        exp_q1.push_back(7'b01_00100);
        send_frame(8'hE0);
        send_frame(8'h75);
        repeat (100) @(posedge clock);
        chk("hold_seen1", {31'd0, holds[1] != 0}, 32'd1);
        exp_q1.push_back(7'b10_00100);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        // Bare 75 without E0 is unmapped everywhere.
        send_frame(8'h75);

        // Player 2 plain cannon key.
        exp_key[1] = 5'b00001;
        exp_q1.push_back(7'b01_00001);
        send_frame(8'h5A);
        repeat (80) @(posedge clock);
        exp_q1.push_back(7'b10_00001);
        send_frame(8'hF0);
        send_frame(8'h5A);

        // Hold angle_up; another key's make/break and a typematic repeat are ignored.
        exp_key[0] = 5'b00100;
        exp_q0.push_back(7'b01_00100);
        send_frame(8'h1D);
        send_frame(8'h1C);
        send_frame(8'hF0);
        send_frame(8'h1C);
        send_frame(8'h1D);
        exp_q0.push_back(7'b10_00100);
        send_frame(8'hF0);
        send_frame(8'h1D);

        // Cannon key with a flipped parity bit.
`ifdef KBD_PARITY_CHECK_EN
        exp_err[0]++;
        exp_err[1]++;
`else
        exp_key[0] = 5'b00001;
        exp_q0.push_back(7'b01_00001);
`endif
        send_frame(8'h29, 1'b1);
`ifndef KBD_PARITY_CHECK_EN
        exp_q0.push_back(7'b10_00001);
`endif
        send_frame(8'hF0);
        send_frame(8'h29);
        repeat (10) @(posedge clock);
        chk("err_left0_parity", exp_err[0], 32'd0);

        // Partial frame of four bits, then silence well past the timeout.
        exp_err[0]++;
        exp_err[1]++;
        $display("[TB] partial frame, 4 bits then stall");
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        ps2_data = 1'b1;
        repeat (250) @(posedge clock);
        chk("err_left0_timeout", exp_err[0], 32'd0);
        chk("err_left1_timeout", exp_err[1], 32'd0);
        exp_key[0] = 5'b00001;
        exp_q0.push_back(7'b01_00001);
        send_frame(8'h29);
        exp_q0.push_back(7'b10_00001);
        send_frame(8'hF0);
        send_frame(8'h29);

        // Framing errors: bad start, bad stop.
        exp_err[0] += 2;
        exp_err[1] += 2;
        send_frame(8'h29, 1'b0, 1'b1, 1'b1);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clock);
        chk("err_left0_framing", exp_err[0], 32'd0);

        // Reset while holding: no release, output cleared right after the edge.
        exp_key[0] = 5'b10000;
        exp_q0.push_back(7'b01_10000);
        send_frame(8'h23);
        repeat (70) @(posedge clock);
        #1;
        rst = 1'b1;
        $display("[TB] reset during hold");
        @(posedge clock);
        #1;
        chk("rst_hold_ki0", {25'd0, ki0}, 32'd0);
        rst = 1'b0;
        repeat (100) @(posedge clock);

        chk("queue0_empty", exp_q0.size(), 32'd0);
        chk("queue1_empty", exp_q1.size(), 32'd0);
        chk("err_left0", exp_err[0], 32'd0);
        chk("err_left1", exp_err[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kbd_event_encoder.md
KBD_EVENT_ENCODER -- requirements
Module: kbd_event_encoder

Interface
REQ-001 SHALL have parameter Position, default 1'b0, selecting the key map: 0 = player 1, 1 = player 2.
REQ-002 SHALL have parameter HOLD_PERIOD, default 23'd5_000_000, giving the clock cycles between hold pulses.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 14'd10_000, giving the PS/2 idle cycles that abort a partial frame.
REQ-004 SHALL have one clock and a synchronous, active-high reset: all state updates on the rising edge of clock; rst high at an edge resets the block.
REQ-005 Port: clock, input, 1, system clock.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: ps2_clk, input, 1, raw asynchronous PS/2 clock.
REQ-008 Port: ps2_data, input, 1, raw asynchronous PS/2 data.
REQ-009 Port: keyboard_input, output, 7, {event[1:0], key[4:0]} as consumed by the player block.
REQ-010 Port: frame_err, output, 1, one-cycle pulse when a frame is dropped.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through a 2-flop synchronizer, then sample data on each synchronized ps2_clk falling edge.
REQ-012 SHALL treat a frame as 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1; a complete frame yields one byte-valid pulse.
REQ-013 SHALL discard a partial frame, return to bit 0, and pulse frame_err when ps2_clk shows no falling edge for TIMEOUT_CYCLES mid-frame.
REQ-014 SHALL drop a frame with start=1 or stop=0 and pulse frame_err.
REQ-015 SHALL set a break flag on byte F0 and an extended flag on byte E0; both flags clear after the next non-prefix byte.
REQ-016 Key map, Position=0: 1D→00100 (angle_up), 1B→00010 (angle_down), 1C→01000 (backward), 23→10000 (forward), 29→00001 (hold_cannon); extended codes unmapped.
REQ-017 Key map, Position=1: E0 75→00100, E0 72→00010, E0 6B→01000, E0 74→10000, 5A non-extended→00001.
REQ-018 Event FSM SHALL have states IDLE, PRESS, HOLD, RELEASE.
REQ-019 IDLE: output 7'b00_00000; a mapped make code latches the key and moves to PRESS.
REQ-020 PRESS: output {01,key} for exactly one cycle; then move to HOLD and clear the hold counter.
REQ-021 HOLD: output {11,key} for one cycle each time the counter reaches HOLD_PERIOD-1 (counter then wraps to 0); output {00,key} on all other cycles.
REQ-022 HOLD: a break of the latched key moves to RELEASE; repeated makes of the latched key (typematic) and all events for other keys SHALL be ignored.
REQ-023 RELEASE: output {10,key} for exactly one cycle, then go to IDLE with key cleared.
REQ-024 A break that coincides with a hold-pulse cycle SHALL take priority: the next cycle is RELEASE and the hold pulse is not extended.
REQ-025 Unmapped makes and breaks SHALL never change the FSM; only one key SHALL be tracked at a time.

Reset
REQ-026 On rst: keyboard_input=0, frame_err=0, FSM=IDLE, prefix flags, bit count and all counters cleared.
REQ-027 Reset during HOLD SHALL emit no negedge event; the output is 0 on the cycle after the reset edge.

Configuration
REQ-028 With KBD_PARITY_CHECK_EN defined, a frame failing odd parity SHALL be dropped and frame_err pulsed.
REQ-029 Without KBD_PARITY_CHECK_EN, the parity bit SHALL be sampled but ignored.

Structure
REQ-030 A shared package kbd_pkg SHALL hold the event codes 01/11/10, the five one-hot key codes, the prefix bytes E0/F0, and the scan-code constants for both key maps.
REQ-031 The frame receiver (REQ-011 to REQ-014, REQ-028, REQ-029) SHALL be a sub-module ps2_rx with outputs byte[7:0], byte_valid and err.

Verification
REQ-032 Position=0, frame 23 → one cycle 7'b01_10000, then 7'b00_10000; after HOLD_PERIOD cycles, one cycle 7'b11_10000.
REQ-033 Position=0, frames 23, F0, 23 → exactly one 7'b10_10000, then 7'b0000000.
REQ-034 Position=1, frames E0 75 then E0 F0 75 → 01_00100, then 10_00100; a bare 75 with no E0 → no event.
REQ-035 Hold 1D, then send 1C make and 1C break → output stays {x,00100} throughout; 1D break → 10_00100.
REQ-036 With KBD_PARITY_CHECK_EN defined, frame 29 with bad parity → frame_err=1 for one cycle and no event; undefined → 01_00001.
REQ-037 Stop ps2_clk after 4 bits for TIMEOUT_CYCLES → frame_err pulse; the next full frame 29 decodes correctly.
